rsa_const_gen: RTL and testbench
================================

RSA_CONST_GEN -- requirements
Module: rsa_const_gen

Interface
REQ-001 Parameter WIDTH, default 8, modulus/result width; internal Montgomery width N = WIDTH+2.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ena  input  1  global enable; when 0 all registers SHALL hold.
REQ-005 clear  input  1  synchronous abort to IDLE.
REQ-006 start  input  1  request computation; sampled only in IDLE.
REQ-007 M  input  WIDTH  modulus; captured on accepted start.
REQ-008 Const  output  WIDTH  Montgomery constant 2^(2N) mod M, fed to the exponentiation unit.
REQ-009 busy  output  1  high in RUN.
REQ-010 done  output  1  high while in DONE.
REQ-011 err  output  1  registered; modulus invalid on last accepted start.

Function
REQ-012 States IDLE, RUN, DONE; transitions occur only on clock edges with ena=1.
REQ-013 IDLE with start=1: capture M into m_q, clear err, set r=1, set iteration counter to 0, go to RUN.
REQ-014 On start, if M is even or M==1: set err=1, r=0, go directly to DONE (skip RUN).
REQ-015 RUN, each enabled cycle: r <= 2r minus m_q if 2r >= m_q, else 2r; counter increments.
REQ-016 Doubling SHALL use WIDTH+1 bits; since r < m_q, one conditional subtract suffices; no overflow.
REQ-017 After exactly 2N RUN iterations (counter reaches 2N-1 and iterates), go to DONE.
REQ-018 Const SHALL be driven from r only in DONE and thereafter; it holds its value until the next accepted start.
REQ-019 Const and err SHALL remain stable during RUN; Const shows the previous result until DONE.
REQ-020 DONE lasts exactly one enabled cycle, then IDLE; with ena=0, done stays high until ena returns.
REQ-021 Latency: with ena held high, done SHALL assert 2N+1 cycles after the start edge (21 cycles for WIDTH=8).
REQ-022 start while in RUN or DONE SHALL be ignored; it is not queued.
REQ-023 clear=1 (with ena=1) in any state: go to IDLE and zero Const and err; clear has priority over start.
REQ-024 M changes after capture SHALL NOT affect the result in progress.

Reset
REQ-025 rst=1 at a clock edge, regardless of ena: state IDLE, Const=0, r=0, counter=0, err=0, busy=0, done=0.
REQ-026 Reset mid-RUN SHALL discard the computation; no done pulse follows.

Structure
REQ-027 Shared package rsa_pkg holds the state enum type and a function/localparam giving N from WIDTH.
REQ-028 Counter width is $clog2(2N+1) and is derived in rsa_pkg.
REQ-029 One sub-module, mod_double_unit (combinational 2r mod m, width WIDTH+1), instantiated once.
REQ-030 The FSM, counter and result registers live in rsa_const_gen.

Verification (WIDTH=8, N=10)
REQ-031 rst, then start with M=251 (0xFB) -> done 21 cycles later, Const=149 (0x95), err=0.
REQ-032 start with M=255 -> Const=16; next start with M=253 -> Const=144; the old Const is held during the second RUN.
REQ-033 start with M=0x80 or M=1 -> done on the next cycle, err=1, Const=0; a following start with M=3 -> Const=1, err=0.
REQ-034 ena toggled low for 5 cycles mid-RUN with M=251 -> done is delayed by 5 cycles, Const=149.
REQ-035 clear pulse at RUN iteration 7 -> IDLE, Const=0, no done; start asserted while busy is ignored.
REQ-036 rst asserted mid-RUN -> all outputs 0 on the next cycle, no done; a subsequent start computes normally.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared definitions for the Montgomery constant generator.
//   state_e    : controller states (IDLE, RUN, DONE)
//   mont_n()   : internal Montgomery width N for a given modulus width
//   cnt_width(): width of the iteration counter, able to hold 0..2N
package rsa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int mont_n(input int width);
    return width + 2;
  endfunction

  function automatic int cnt_width(input int width);
    return $clog2(2 * mont_n(width) + 1);
  endfunction

endpackage

// File: rtl/rsa_const_gen_if.sv
// Control/result bundle between a requester and rsa_const_gen.
//   ena, clear, start, M : requester -> generator
//   Const, busy, done, err : generator -> requester
interface rsa_const_gen_if #(
  parameter int WIDTH = 8
);
  logic             ena;
  logic             clear;
  logic             start;
  logic [WIDTH-1:0] M;
  logic [WIDTH-1:0] Const;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output ena, clear, start, M,
    input  Const, busy, done, err
  );

  modport slave (
    input  ena, clear, start, M,
    output Const, busy, done, err
  );
endinterface

// File: rtl/mod_double_unit.sv
// Combinational modular doubling: res_o = (2 * r_i) mod m_i.
//   r_i   : current residue, must satisfy r_i < m_i
//   m_i   : modulus
//   res_o : doubled residue, again < m_i
// Because r_i < m_i, 2*r_i < 2*m_i, so a single conditional subtract on a
// WIDTH+1 bit intermediate is exact and cannot overflow.
module mod_double_unit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] res_o
);

  logic [WIDTH:0] dbl;
  logic [WIDTH:0] diff;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    res_o = '0;
    dbl   = {r_i, 1'b0};
    diff  = dbl - {1'b0, m_i};
    if (dbl >= {1'b0, m_i}) begin
      res_o = diff[WIDTH-1:0];
    end else begin
      res_o = dbl[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/rsa_const_gen.sv
// Montgomery constant generator: computes Const = 2^(2N) mod M, N = WIDTH+2,
// by 2N modular doublings of r starting from r = 1.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, honoured regardless of ena
//   bus  : slave side of rsa_const_gen_if (ena/clear/start/M in,
//          Const/busy/done/err out)
// Timing with ena high: start accepted at edge 0, iterations on edges 1..2N,
// edge 2N+1 loads the result and enters DONE for a single enabled cycle.
module rsa_const_gen
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  rsa_const_gen_if.slave     bus
);

  localparam int N  = mont_n(WIDTH);
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(2 * N);

  state_e           state_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] const_q;
  logic [CW-1:0]    cnt_q;
  logic             err_q;
  logic             busy_q;
  logic             done_q;
  logic             m_invalid;

  // Montgomery needs an odd modulus greater than one.
  assign m_invalid = ~bus.M[0] | (bus.M == WIDTH'(1));

  mod_double_unit #(.WIDTH(WIDTH)) u_double (
    .r_i   (r_q),
    .m_i   (m_q),
    .res_o (r_d)
  );

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      r_q     <= '0;
      const_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.ena) begin
      if (bus.clear) begin
        state_q <= ST_IDLE;
        r_q     <= '0;
        const_q <= '0;
        cnt_q   <= '0;
        err_q   <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            done_q <= 1'b0;
            if (bus.start) begin
              m_q   <= bus.M;
              cnt_q <= '0;
              if (m_invalid) begin
                // Bad modulus: report immediately with a zero result.
                err_q   <= 1'b1;
                r_q     <= '0;
                const_q <= '0;
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end else begin
                err_q   <= 1'b0;
                r_q     <= WIDTH'(1);
                state_q <= ST_RUN;
                busy_q  <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (cnt_q == LAST_CNT) begin
              // All 2N doublings are in r_q; publish it.
              const_q <= r_q;
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              r_q   <= r_d;
              cnt_q <= cnt_q + CW'(1);
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.Const = const_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_rsa_const_gen.sv
module tb_rsa_const_gen;
  localparam int WIDTH = 8;
  localparam int N     = WIDTH + 2;
  localparam int LAT   = 2 * N + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rsa_const_gen_if #(.WIDTH(WIDTH)) bus ();
  rsa_const_gen #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] model_const = '0;

  function automatic bit ref_err(input logic [WIDTH-1:0] m);
    return (m % 2 == 0) || (m == 1);
  endfunction

  function automatic logic [WIDTH-1:0] ref_const(input logic [WIDTH-1:0] m);
    longint unsigned p;
    if (ref_err(m)) return '0;
    p = (64'd1 << (2 * N)) % longint'(m);
    return WIDTH'(p);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [WIDTH-1:0] m);
    bus.M     = m;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.M     = WIDTH'($urandom);
  endtask

  // Ticks until done; lat = ticks since call, -1 on timeout. stable drops if
  // busy/Const/err misbehave while waiting.
  task automatic run_to_done(input int budget, input logic [WIDTH-1:0] hold,
                             output int lat, output bit stable);
    lat = 0;
    stable = 1'b1;
    while (bus.done !== 1'b1 && lat < budget) begin
      if (bus.busy !== 1'b1 || bus.Const !== hold || bus.err !== 1'b0) stable = 1'b0;
      tick();
      lat++;
    end
    if (bus.done !== 1'b1) lat = -1;
  endtask

  task automatic valid_run(input string name, input logic [WIDTH-1:0] m);
    int lat;
    bit stable;
    logic [WIDTH-1:0] exp_c;
    exp_c = ref_const(m);
    start_op(m);
    run_to_done(200, model_const, lat, stable);
    checks++;
    if (lat !== LAT) begin
      failures++;
      $display("FAIL %s latency: got %0d expected %0d (M=%0d)", name, lat, LAT, m);
    end
    checks++;
    if (bus.Const !== exp_c || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL %s result: Const=%0d err=%b expected Const=%0d err=0 (M=%0d)",
               name, bus.Const, bus.err, exp_c, m);
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL %s run_stability: outputs changed during RUN, expected busy=1 Const=%0d",
               name, model_const);
    end
    model_const = exp_c;
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s done_pulse: done=%b busy=%b expected 0 0", name, bus.done, bus.busy);
    end
  endtask

  task automatic invalid_run(input string name, input logic [WIDTH-1:0] m);
    start_op(m);
    checks++;
    if (bus.done !== 1'b1 || bus.err !== 1'b1 || bus.Const !== '0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s invalid: done=%b err=%b Const=%0d busy=%b expected 1 1 0 0 (M=%0d)",
               name, bus.done, bus.err, bus.Const, bus.busy, m);
    end
    model_const = '0;
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      failures++;
      $display("FAIL %s invalid_done_pulse: done=%b expected 0", name, bus.done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (bus.Const !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: Const=%0d busy=%b done=%b err=%b expected all 0",
               bus.Const, bus.busy, bus.done, bus.err);
    end
    model_const = '0;
  endtask

  task automatic test_basic();
    valid_run("basic_251", 8'd251);
  endtask

  task automatic test_back_to_back();
    valid_run("b2b_255", 8'd255);
    valid_run("b2b_253", 8'd253);
  endtask

  task automatic test_invalid();
    invalid_run("inv_0x80", 8'h80);
    invalid_run("inv_1", 8'd1);
    valid_run("after_inv_3", 8'd3);
    invalid_run("inv_0", 8'd0);
  endtask

  task automatic test_enable();
    int lat;
    bit stable;
    start_op(8'd251);
    repeat (4) tick();
    bus.ena = 1'b0;
    repeat (5) tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL ena_hold: busy=%b done=%b expected 1 0", bus.busy, bus.done);
    end
    bus.ena = 1'b1;
    run_to_done(200, model_const, lat, stable);
    if (lat >= 0) lat += 9;
    checks++;
    if (lat !== LAT + 5 || bus.Const !== ref_const(8'd251)) begin
      failures++;
      $display("FAIL ena_delay: latency=%0d Const=%0d expected %0d %0d",
               lat, bus.Const, LAT + 5, ref_const(8'd251));
    end
    model_const = ref_const(8'd251);
    // done must persist while disabled.
    bus.ena = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.done !== 1'b1) begin
      failures++;
      $display("FAIL ena_done_hold: done=%b expected 1", bus.done);
    end
    bus.ena = 1'b1;
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      failures++;
      $display("FAIL ena_done_release: done=%b expected 0", bus.done);
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    bit stable;
    logic [WIDTH-1:0] m1;
    m1 = 8'd251;
    start_op(m1);
    repeat (3) tick();
    start_op(8'd3);   // ignored in RUN
    run_to_done(200, model_const, lat, stable);
    if (lat >= 0) lat += 4;
    checks++;
    if (lat !== LAT || bus.Const !== ref_const(m1) || !stable) begin
      failures++;
      $display("FAIL start_in_run: latency=%0d Const=%0d stable=%b expected %0d %0d 1",
               lat, bus.Const, stable, LAT, ref_const(m1));
    end
    model_const = ref_const(m1);
    // start during DONE is ignored: next state is IDLE, not RUN.
    start_op(8'd3);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Const !== model_const) begin
      failures++;
      $display("FAIL start_in_done: busy=%b done=%b Const=%0d expected 0 0 %0d",
               bus.busy, bus.done, bus.Const, model_const);
    end
  endtask

  task automatic test_clear();
    bit saw_done;
    start_op(8'd251);
    repeat (7) tick();
    bus.clear = 1'b1;
    bus.start = 1'b1;
    bus.M     = 8'd3;
    tick();
    bus.clear = 1'b0;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Const !== '0 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL clear_run: busy=%b done=%b Const=%0d err=%b expected 0 0 0 0",
               bus.busy, bus.done, bus.Const, bus.err);
    end
    model_const = '0;
    saw_done = 1'b0;
    repeat (30) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL clear_no_done: activity=1 expected 0");
    end
    // err cleared by clear; clear beats start in IDLE.
    invalid_run("clr_prep", 8'd2);
    bus.clear = 1'b1;
    bus.start = 1'b1;
    bus.M     = 8'd251;
    tick();
    bus.clear = 1'b0;
    bus.start = 1'b0;
    checks++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL clear_priority: err=%b busy=%b done=%b expected 0 0 0",
               bus.err, bus.busy, bus.done);
    end
  endtask

  task automatic test_reset_mid_run();
    bit saw_done;
    valid_run("pre_rst", 8'd251);
    start_op(8'd253);
    repeat (8) tick();
    bus.ena = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.ena = 1'b1;
    checks++;
    if (bus.Const !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_run: Const=%0d busy=%b done=%b err=%b expected all 0",
               bus.Const, bus.busy, bus.done, bus.err);
    end
    model_const = '0;
    saw_done = 1'b0;
    repeat (30) begin
      tick();
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL rst_no_done: done seen=1 expected 0");
    end
    valid_run("post_rst", 8'd251);
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] m;
    for (int i = 0; i < 24; i++) begin
      m = WIDTH'($urandom_range(0, 255));
      if (i % 4 != 3) m[0] = 1'b1;
      if (ref_err(m)) invalid_run("rand", m);
      else valid_run("rand", m);
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.ena   = 1'b1;
    bus.clear = 1'b0;
    bus.start = 1'b0;
    bus.M     = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_invalid();
    test_enable();
    test_start_ignored();
    test_clear();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
